// File: rtl/sync_fifo_pkg.sv
// Shared types and elaboration helpers for the parametrised single-clock FIFO.
// Status flags are bundled so the top can register them as one word.
package sync_fifo_pkg;

  typedef struct packed {
    logic full;
    logic empty;
    logic almost_full;
    logic almost_empty;
  } fifo_status_t;

  localparam fifo_status_t STATUS_RST = '{
    full:         1'b0,
    empty:        1'b1,
    almost_full:  1'b0,
    almost_empty: 1'b1
  };

  // Pointer width carries one extra wrap bit above the address bits.
  function automatic int ptr_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

  function automatic bit is_pow2(input int v);
    return (v > 0) && ((v & (v - 1)) == 0);
  endfunction

  function automatic fifo_status_t status_of(input int cnt, input int depth,
                                             input int af_thresh, input int ae_thresh);
    fifo_status_t s;
    s.full         = (cnt == depth);
    s.empty        = (cnt == 0);
    s.almost_full  = (cnt >= af_thresh);
    s.almost_empty = (cnt <= ae_thresh);
    return s;
  endfunction

endpackage

// File: rtl/fifo_mem.sv
// DEPTH x DATA_W storage: one synchronous write port, one registered read port.
// Read data appears one cycle after rd_en_i and holds until the next read; no backpressure.
module fifo_mem #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 16,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              wr_en_i,
  input  logic [ADDR_W-1:0] wr_addr_i,
  input  logic [DATA_W-1:0] wr_data_i,
  input  logic              rd_en_i,
  input  logic [ADDR_W-1:0] rd_addr_i,
  output logic [DATA_W-1:0] rd_data_o
);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] rd_data_q;

  // Storage array is intentionally left unreset.
  always_ff @(posedge clk_i) begin
    if (wr_en_i) begin
      mem_q[wr_addr_i] <= wr_data_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rd_data_q <= '0;
    end else if (rd_en_i) begin
      rd_data_q <= mem_q[rd_addr_i];
    end
  end

  assign rd_data_o = rd_data_q;

endmodule

// File: rtl/sync_fifo_param.sv
// Parametrised single-clock FIFO with occupancy, almost flags, flush and sticky errors.
// 1-cycle registered read latency; writes when full (without a read) are dropped and flagged.
module sync_fifo_param
  import sync_fifo_pkg::*;
#(
  parameter int DATA_W    = 8,
  parameter int DEPTH     = 16,
  parameter int AF_THRESH = DEPTH - 2,
  parameter int AE_THRESH = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   clr,
  input  logic                   wr,
  input  logic [DATA_W-1:0]      d_in,
  input  logic                   rd,
  output logic [DATA_W-1:0]      d_out,
  output logic                   full,
  output logic                   empty,
  output logic                   almost_full,
  output logic                   almost_empty,
  output logic [$clog2(DEPTH):0] count,
  output logic                   overflow,
  output logic                   underflow
);

  localparam int PTR_W  = ptr_w(DEPTH);
  localparam int ADDR_W = PTR_W - 1;

  if (!is_pow2(DEPTH) || DEPTH < 4) begin : g_bad_depth
    $error("sync_fifo_param: DEPTH must be a power of 2 and at least 4");
  end

  if (!(AE_THRESH < AF_THRESH && AF_THRESH <= DEPTH)) begin : g_bad_thresh
    $error("sync_fifo_param: thresholds must satisfy AE_THRESH < AF_THRESH <= DEPTH");
  end

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] count_q,  count_d;
  fifo_status_t     status_q, status_d;
  logic             ovf_q, ovf_d;
  logic             unf_q, unf_d;
  logic             wr_ok, rd_ok;

  // Flush wins over both requests; a full FIFO still accepts a write paired with a read.
  always_comb begin
    wr_ok = !clr && wr && (!status_q.full || rd);
    rd_ok = !clr && rd && !status_q.empty;
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    ovf_d    = ovf_q;
    unf_d    = unf_q;
    if (clr) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
      ovf_d    = 1'b0;
      unf_d    = 1'b0;
    end else begin
      if (wr_ok) begin
        wr_ptr_d = wr_ptr_q + PTR_W'(1);
      end
      if (rd_ok) begin
        rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      unique case ({wr_ok, rd_ok})
        2'b10:   count_d = count_q + PTR_W'(1);
        2'b01:   count_d = count_q - PTR_W'(1);
        default: count_d = count_q;
      endcase
      if (wr && status_q.full && !rd) begin
        ovf_d = 1'b1;
      end
      if (rd && status_q.empty) begin
        unf_d = 1'b1;
      end
    end
  end

  // Flags track the post-edge occupancy so they change on the same edge as count.
  always_comb begin
    status_d = status_of(int'(count_d), DEPTH, AF_THRESH, AE_THRESH);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      status_q <= STATUS_RST;
      ovf_q    <= 1'b0;
      unf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      status_q <= status_d;
      ovf_q    <= ovf_d;
      unf_q    <= unf_d;
    end
  end

  fifo_mem #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_mem (
    .clk_i     (clk),
    .rst_ni    (rst),
    .wr_en_i   (wr_ok),
    .wr_addr_i (wr_ptr_q[ADDR_W-1:0]),
    .wr_data_i (d_in),
    .rd_en_i   (rd_ok),
    .rd_addr_i (rd_ptr_q[ADDR_W-1:0]),
    .rd_data_o (d_out)
  );

  assign count        = count_q;
  assign full         = status_q.full;
  assign empty        = status_q.empty;
  assign almost_full  = status_q.almost_full;
  assign almost_empty = status_q.almost_empty;
  assign overflow     = ovf_q;
  assign underflow    = unf_q;

  // Wrap-bit pointer distance must always agree with the tracked occupancy.
  a_ptr_count: assert property (@(posedge clk) disable iff (!rst)
    (PTR_W'(wr_ptr_q - rd_ptr_q) == count_q));

endmodule

// File: tb/tb_sync_fifo_param.sv
// Bench for sync_fifo_param (DEPTH=16, DATA_W=8): fixed vector table plus model-driven sequences.
module tb_sync_fifo_param;

  localparam int DW = 8;
  localparam int D  = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic          clr;
  logic          wr;
  logic          rd;
  logic [DW-1:0] d_in;
  logic [DW-1:0] d_out;
  logic          full;
  logic          empty;
  logic          almost_full;
  logic          almost_empty;
  logic [4:0]    count;
  logic          overflow;
  logic          underflow;

  sync_fifo_param #(
    .DATA_W    (DW),
    .DEPTH     (D),
    .AF_THRESH (D - 2),
    .AE_THRESH (2)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .clr          (clr),
    .wr           (wr),
    .d_in         (d_in),
    .rd           (rd),
    .d_out        (d_out),
    .full         (full),
    .empty        (empty),
    .almost_full  (almost_full),
    .almost_empty (almost_empty),
    .count        (count),
    .overflow     (overflow),
    .underflow    (underflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic          clr;
    logic          wr;
    logic          rd;
    logic [DW-1:0] din;
    int            cnt;
    logic          full;
    logic          empty;
    logic          af;
    logic          ae;
    logic          ovf;
    logic          unf;
    logic [DW-1:0] dout;
  } vec_t;

  vec_t          tbl[13];
  logic [DW-1:0] mq[$];
  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] m_dout;
  bit            m_ovf;
  bit            m_unf;
  int            checks;
  int            errors;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    exp_q.delete();
    m_dout = '0;
    m_ovf  = 1'b0;
    m_unf  = 1'b0;
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, " count"},     int'(count),        0);
    check({tag, " empty"},     int'(empty),        1);
    check({tag, " full"},      int'(full),         0);
    check({tag, " aempty"},    int'(almost_empty), 1);
    check({tag, " afull"},     int'(almost_full),  0);
    check({tag, " overflow"},  int'(overflow),     0);
    check({tag, " underflow"}, int'(underflow),    0);
    check({tag, " d_out"},     int'(d_out),        0);
  endtask

  // Drive one cycle; the model predicts pre-edge, the scoreboard is popped after the edge.
  task automatic step(input logic c, input logic w, input logic r, input logic [DW-1:0] d);
    bit m_full;
    bit m_empty;
    m_full  = (mq.size() == D);
    m_empty = (mq.size() == 0);
    if (c) begin
      mq.delete();
      m_ovf = 1'b0;
      m_unf = 1'b0;
    end else begin
      if (w && m_full && !r) m_ovf = 1'b1;
      if (r && m_empty) m_unf = 1'b1;
      if (r && !m_empty) exp_q.push_back(mq.pop_front());
      if (w && (!m_full || r)) mq.push_back(d);
    end
    clr  = c;
    wr   = w;
    rd   = r;
    d_in = d;
    @(posedge clk);
    #1;
    if (exp_q.size() > 0) m_dout = exp_q.pop_front();
    check("count",     int'(count),        mq.size());
    check("full",      int'(full),         int'(mq.size() == D));
    check("empty",     int'(empty),        int'(mq.size() == 0));
    check("afull",     int'(almost_full),  int'(mq.size() >= D - 2));
    check("aempty",    int'(almost_empty), int'(mq.size() <= 2));
    check("overflow",  int'(overflow),     int'(m_ovf));
    check("underflow", int'(underflow),    int'(m_unf));
    check("d_out",     int'(d_out),        int'(m_dout));
  endtask

  task automatic idle();
    clr  = 1'b0;
    wr   = 1'b0;
    rd   = 1'b0;
    d_in = '0;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    model_reset();
    rst = 1'b0;
    idle();

    //              clr  wr   rd   din    cnt full empt af   ae   ovf  unf  dout
    tbl[0]  = '{1'b0, 1'b1, 1'b0, 8'h11, 1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00};
    tbl[1]  = '{1'b0, 1'b1, 1'b0, 8'h22, 2, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00};
    tbl[2]  = '{1'b0, 1'b1, 1'b0, 8'h33, 3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00};
    tbl[3]  = '{1'b0, 1'b0, 1'b1, 8'h00, 2, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h11};
    tbl[4]  = '{1'b0, 1'b1, 1'b1, 8'h44, 2, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h22};
    tbl[5]  = '{1'b0, 1'b0, 1'b1, 8'h00, 1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h33};
    tbl[6]  = '{1'b0, 1'b0, 1'b1, 8'h00, 0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'h44};
    tbl[7]  = '{1'b0, 1'b0, 1'b1, 8'h00, 0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 8'h44};
    tbl[8]  = '{1'b0, 1'b1, 1'b1, 8'h55, 1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 8'h44};
    tbl[9]  = '{1'b1, 1'b0, 1'b0, 8'h00, 0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'h44};
    tbl[10] = '{1'b1, 1'b1, 1'b0, 8'h66, 0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'h44};
    tbl[11] = '{1'b0, 1'b0, 1'b1, 8'h00, 0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 8'h44};
    tbl[12] = '{1'b1, 1'b0, 1'b0, 8'h00, 0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'h44};

    repeat (2) @(posedge clk);
    #1;
    check_reset_state("reset");
    #3 rst = 1'b1;

    // Fixed vectors with hand-derived expectations.
    for (int i = 0; i < 13; i++) begin
      step(tbl[i].clr, tbl[i].wr, tbl[i].rd, tbl[i].din);
      check($sformatf("tbl%0d count", i),     int'(count),        tbl[i].cnt);
      check($sformatf("tbl%0d full", i),      int'(full),         int'(tbl[i].full));
      check($sformatf("tbl%0d empty", i),     int'(empty),        int'(tbl[i].empty));
      check($sformatf("tbl%0d afull", i),     int'(almost_full),  int'(tbl[i].af));
      check($sformatf("tbl%0d aempty", i),    int'(almost_empty), int'(tbl[i].ae));
      check($sformatf("tbl%0d overflow", i),  int'(overflow),     int'(tbl[i].ovf));
      check($sformatf("tbl%0d underflow", i), int'(underflow),    int'(tbl[i].unf));
      check($sformatf("tbl%0d d_out", i),     int'(d_out),        int'(tbl[i].dout));
    end

    // Fill to full then drain in order.
    for (int i = 1; i <= D; i++) step(1'b0, 1'b1, 1'b0, DW'(i));
    check("fill full", int'(full), 1);
    check("fill count", int'(count), D);
    for (int i = 1; i <= D; i++) begin
      step(1'b0, 1'b0, 1'b1, 8'h00);
      check("drain order", int'(d_out), i);
    end
    check("drain empty", int'(empty), 1);

    // Write while full is dropped and flagged.
    for (int i = 0; i < D; i++) step(1'b0, 1'b1, 1'b0, DW'(8'h30 + i));
    step(1'b0, 1'b1, 1'b0, 8'hAA);
    check("ovf set", int'(overflow), 1);
    for (int i = 0; i < D; i++) begin
      step(1'b0, 1'b0, 1'b1, 8'h00);
      check("no AA", int'(d_out == 8'hAA), 0);
    end

    // Read while empty, then flush clears the sticky flags.
    step(1'b0, 1'b0, 1'b1, 8'h00);
    check("unf set", int'(underflow), 1);
    step(1'b1, 1'b0, 1'b0, 8'h00);
    check("unf clr", int'(underflow), 0);
    check("ovf clr", int'(overflow), 0);

    // Full with simultaneous read and write across pointer wrap.
    for (int i = 0; i < D; i++) step(1'b0, 1'b1, 1'b0, DW'(i));
    for (int i = 0; i < 20; i++) begin
      step(1'b0, 1'b1, 1'b1, DW'(8'h80 + i));
      check("rw full count", int'(count), D);
    end
    for (int i = 0; i < D; i++) step(1'b0, 1'b0, 1'b1, 8'h00);

    // Flush beats a same-cycle write.
    for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 1'b0, DW'(8'h90 + i));
    step(1'b1, 1'b1, 1'b0, 8'h99);
    check("clr+wr count", int'(count), 0);

    // Asynchronous reset mid-cycle.
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b0, DW'(8'hC0 + i));
    step(1'b0, 1'b0, 1'b1, 8'h00);
    idle();
    #2 rst = 1'b0;
    #1;
    check_reset_state("async rst");
    model_reset();
    #3 rst = 1'b1;
    step(1'b0, 1'b1, 1'b0, 8'h5A);
    step(1'b0, 1'b0, 1'b1, 8'h00);
    check("post rst data", int'(d_out), 8'h5A);
    idle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
